instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The module SHALL take parameter RESET_PC, default 32'h0000_0000, as the first fetch address after reset.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 hazard_stall_i  input  1  load-use stall from the hazard detection unit; IF/ID register holds.
REQ-005 flush_i  input  1  redirect request from EX (taken branch/jump/trap).
REQ-006 target_pc_i  input  32  redirect address, sampled when flush_i=1.
REQ-007 imem_req_o  output  1  instruction memory request; always accepted in the cycle it is asserted.
REQ-008 imem_addr_o  output  32  request address, valid while imem_req_o=1.
REQ-009 imem_rvalid_i  input  1  response valid; in order, latency >=1 cycle.
REQ-010 imem_rdata_i  input  32  response instruction.
REQ-011 instr_o  output  32  IF/ID instruction; SHALL equal NOP (32'h0000_0013) whenever valid_o=0.
REQ-012 pc_o  output  32  IF/ID address of instr_o.
REQ-013 valid_o  output  1  IF/ID entry valid.

Function
REQ-014 The module SHALL keep at most one outstanding memory request.
REQ-015 The FSM SHALL use exactly three states. RUN: no request outstanding. WAIT: a request is outstanding. KILL: an outstanding request's response is to be discarded.
REQ-016 fetch_pc SHALL increment by 4 on every issued request and wrap modulo 2^32.
REQ-017 The skid buffer SHALL hold one entry (instr, pc, full).
REQ-018 imem_req_o SHALL be 1 only when all of the following hold: flush_i=0; state!=KILL; state==RUN, or state==WAIT with imem_rvalid_i=1; the skid buffer is empty after this cycle.
REQ-019 imem_addr_o SHALL equal fetch_pc.
REQ-020 A response in WAIT with hazard_stall_i=0 and the skid buffer empty SHALL load the IF/ID register directly. Latency is request cycle + memory latency; back-to-back issue gives 1 instruction per cycle.
REQ-021 A response in WAIT with hazard_stall_i=1 and valid_o=1 SHALL be written to the skid buffer.
REQ-022 With hazard_stall_i=0 and the skid buffer full, the IF/ID register SHALL load from the skid buffer and the buffer SHALL empty.
REQ-023 With hazard_stall_i=0 and no data available, valid_o SHALL go to 0 (bubble).
REQ-024 hazard_stall_i=1 SHALL leave instr_o, pc_o and valid_o unchanged.
REQ-025 flush_i=1 SHALL take priority over hazard_stall_i.
REQ-026 flush_i=1 SHALL clear valid_o and the skid buffer and set fetch_pc to target_pc_i.
REQ-027 flush_i=1 SHALL move WAIT to KILL, unless imem_rvalid_i=1 in the same cycle, in which case the response is dropped and the state moves to RUN.
REQ-028 flush_i=1 SHALL move KILL to KILL, unless imem_rvalid_i=1 in the same cycle, in which case the state moves to RUN.
REQ-029 In KILL, imem_rvalid_i=1 SHALL discard the response and move to RUN; the first request to target_pc_i SHALL issue no earlier than the cycle after that.
REQ-030 A flush in RUN SHALL issue the request to target_pc_i in the following cycle.

Reset
REQ-031 Asserting reset_i SHALL immediately set: state=RUN, fetch_pc=RESET_PC, valid_o=0, instr_o=NOP, pc_o=RESET_PC, skid buffer empty.
REQ-032 A response arriving after reset for a request issued before reset SHALL be ignored by the module; the memory is also reset by the system.
REQ-033 imem_req_o SHALL be 0 while reset_i=1 and SHALL first assert, with address RESET_PC, in the first clock after deassertion.

Configuration
REQ-034 With IFU_STALL_CNT_EN defined, the module SHALL add output stall_cycles_o (32 bits): reset to 0, +1 per cycle with hazard_stall_i=1 and flush_i=0, saturating at 32'hFFFF_FFFF.
REQ-035 Without IFU_STALL_CNT_EN, the port and the counter SHALL be absent.

Structure
REQ-036 The shared package SHALL hold: NOP encoding 32'h0000_0013, the FSM state typedef (RUN/WAIT/KILL), and the instruction width of 32.
REQ-037 The skid buffer SHALL be the sub-module ifu_skid_buffer (one entry: instr, pc, full; load/drain/clear ports).
REQ-038 The PC register, FSM and IF/ID register SHALL reside in instruction_fetch_unit.

Verification
REQ-039 Reset release, RESET_PC=0x100, 1-cycle memory, no stalls -> requests to 0x100, 0x104, 0x108 on consecutive cycles; pc_o=0x100 with valid_o=1 two cycles after release.
REQ-040 hazard_stall_i high 2 cycles while instr at 0x104 is in IF/ID -> pc_o holds 0x104; response 0x108 goes to the skid buffer; no request issued while the skid is full; 0x108 appears the cycle after the stall drops.
REQ-041 flush_i=1, target 0x200, while the request to 0x10C is outstanding with 3-cycle latency -> 0x10C response discarded, valid_o=0 meanwhile; next request address 0x200.
REQ-042 flush_i and hazard_stall_i high in the same cycle -> valid_o=0; the next valid instruction has pc_o=0x200.
REQ-043 fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-044 reset_i asserted mid-WAIT, then a stale imem_rvalid_i pulse after release -> ignored; the first request goes to RESET_PC; with IFU_STALL_CNT_EN, stall_cycles_o=0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: instruction width,
// NOP encoding and the fetch FSM state type.
package instruction_fetch_unit_pkg;

  localparam int INSTR_W = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/ifu_skid_buffer.sv
// One-entry skid buffer that parks a fetched instruction while IF/ID is stalled.
// Priority: clear, then load, then drain.
module ifu_skid_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [31:0]        load_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc,
  output logic               full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      instr <= NOP;
      pc    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, RUN/WAIT/KILL fetch FSM and the IF/ID register.
// Optional feature: define IFU_STALL_CNT_EN to add the stall_cycles_o counter.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               hazard_stall_i,
  input  logic               flush_i,
  input  logic [31:0]        target_pc_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
`ifdef IFU_STALL_CNT_EN
  output logic [31:0]        stall_cycles_o,
`endif
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o,
  output logic               valid_o
);

  ifu_state_t         state;
  logic [31:0]        fetch_pc;
  logic [31:0]        req_pc;
  logic               resp_ok;
  logic               skid_full;
  logic               skid_full_next;
  logic               skid_load;
  logic               skid_drain;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc;

  // A response is only usable in WAIT and when no redirect is happening.
  assign resp_ok        = (state == WAIT) && imem_rvalid_i && !flush_i;
  assign skid_load      = resp_ok && hazard_stall_i;
  assign skid_drain     = !flush_i && !hazard_stall_i && skid_full;
  assign skid_full_next = !flush_i && hazard_stall_i && (skid_full || resp_ok);

  assign imem_req_o  = !reset_i && !flush_i && !skid_full_next &&
                       ((state == RUN) || ((state == WAIT) && imem_rvalid_i));
  assign imem_addr_o = fetch_pc;

  ifu_skid_buffer u_skid (
    .clk        (clk_i),
    .rst        (reset_i),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (flush_i),
    .load_instr (imem_rdata_i),
    .load_pc    (req_pc),
    .instr      (skid_instr),
    .pc         (skid_pc),
    .full       (skid_full)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:  if (imem_req_o) state <= WAIT;
        WAIT: begin
          if (flush_i)            state <= imem_rvalid_i ? RUN : KILL;
          else if (imem_rvalid_i) state <= imem_req_o ? WAIT : RUN;
        end
        KILL: if (imem_rvalid_i) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else if (flush_i) begin
      fetch_pc <= target_pc_i;
    end else if (imem_req_o) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
      instr_o <= NOP;
      pc_o    <= RESET_PC;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      instr_o <= NOP;
    end else if (!hazard_stall_i) begin
      if (skid_full) begin
        valid_o <= 1'b1;
        instr_o <= skid_instr;
        pc_o    <= skid_pc;
      end else if (resp_ok) begin
        valid_o <= 1'b1;
        instr_o <= imem_rdata_i;
        pc_o    <= req_pc;
      end else begin
        valid_o <= 1'b0;
        instr_o <= NOP;
      end
    end
  end

`ifdef IFU_STALL_CNT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cycles_o <= '0;
    end else if (hazard_stall_i && !flush_i && (stall_cycles_o != 32'hFFFF_FFFF)) begin
      stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with a one-outstanding memory model
// of programmable latency; optional stall counter checked when IFU_STALL_CNT_EN is set.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hazard_stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
`ifdef IFU_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int fails  = 0;
  int lat    = 1;

  // memory model state
  logic        pend;
  logic [31:0] pend_addr;
  int          rem;
  logic        inj_rvalid = 1'b0;
  logic [31:0] inj_data   = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
      rem  <= 0;
    end else if (imem_req) begin
      pend      <= 1'b1;
      pend_addr <= imem_addr;
      rem       <= lat;
    end else if (pend) begin
      if (rem == 1) pend <= 1'b0;
      else          rem  <= rem - 1;
    end
  end

  assign imem_rvalid = (pend && rem == 1) || inj_rvalid;
  assign imem_rdata  = inj_rvalid ? inj_data : mem_word(pend_addr);

  instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .hazard_stall_i (hazard_stall),
    .flush_i        (flush),
    .target_pc_i    (target_pc),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_rvalid_i  (imem_rvalid),
    .imem_rdata_i   (imem_rdata),
`ifdef IFU_STALL_CNT_EN
    .stall_cycles_o (stall_cycles),
`endif
    .instr_o        (instr),
    .pc_o           (pc),
    .valid_o        (valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    step();
    step();
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %h want 0", imem_req); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %h want 0", valid); end
    checks++; if (instr !== NOP_W) begin fails++; $display("FAIL rst_instr got %h want %h", instr, NOP_W); end
    checks++; if (pc !== RST_PC) begin fails++; $display("FAIL rst_pc got %h want %h", pc, RST_PC); end
`ifdef IFU_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL rst_stallcnt got %0d want 0", stall_cycles); end
`endif
    $display("reset: req=%0b valid=%0b pc=%h", imem_req, valid, pc);
  endtask

  task automatic test_fetch_stream();
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin fails++; $display("FAIL first_req got %0b/%h want 1/%h", imem_req, imem_addr, RST_PC); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin fails++; $display("FAIL req_104 got %0b/%h want 1/104", imem_req, imem_addr); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL early_valid got %0b want 0", valid); end
    step();
    checks++; if (valid !== 1'b1 || pc !== RST_PC) begin fails++; $display("FAIL first_instr got %0b/%h want 1/%h", valid, pc, RST_PC); end
    checks++; if (instr !== mem_word(RST_PC)) begin fails++; $display("FAIL first_data got %h want %h", instr, mem_word(RST_PC)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin fails++; $display("FAIL req_108 got %0b/%h want 1/108", imem_req, imem_addr); end
    $display("fetch_stream: pc=%h instr=%h next_addr=%h", pc, instr, imem_addr);
  endtask

  task automatic test_stall_skid();
    step();
    checks++; if (valid !== 1'b1 || pc !== 32'h104) begin fails++; $display("FAIL b2b_104 got %0b/%h want 1/104", valid, pc); end
    hazard_stall = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_noreq1 got %0b want 0", imem_req); end
    step();
    checks++; if (pc !== 32'h104 || valid !== 1'b1) begin fails++; $display("FAIL stall_hold1 got %0b/%h want 1/104", valid, pc); end
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_noreq2 got %0b want 0", imem_req); end
    step();
    checks++; if (pc !== 32'h104 || instr !== mem_word(32'h104)) begin fails++; $display("FAIL stall_hold2 got %h/%h want 104/%h", pc, instr, mem_word(32'h104)); end
    hazard_stall = 1'b0;
    lat = 3;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin fails++; $display("FAIL req_10c got %0b/%h want 1/10c", imem_req, imem_addr); end
    step();
    checks++; if (valid !== 1'b1 || pc !== 32'h108 || instr !== mem_word(32'h108)) begin fails++; $display("FAIL skid_out got %0b/%h/%h want 1/108/%h", valid, pc, instr, mem_word(32'h108)); end
`ifdef IFU_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd2) begin fails++; $display("FAIL stallcnt2 got %0d want 2", stall_cycles); end
`endif
    $display("stall_skid: pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_flush_kill();
    flush = 1'b1;
    target_pc = 32'h200;
    #1;
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL flush_noreq got %0b want 0", imem_req); end
    step();
    flush = 1'b0;
    checks++; if (valid !== 1'b0 || instr !== NOP_W) begin fails++; $display("FAIL flush_bubble got %0b/%h want 0/%h", valid, instr, NOP_W); end
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL kill_noreq1 got %0b want 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL kill_noreq2 got req=%0b valid=%0b want 0/0", imem_req, valid); end
    step();
    lat = 1;
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL kill_discard got %0b want 0", valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL req_200 got %0b/%h want 1/200", imem_req, imem_addr); end
    step();
    checks++; if (valid !== 1'b0 || imem_addr !== 32'h204) begin fails++; $display("FAIL req_204 got %0b/%h want 0/204", valid, imem_addr); end
    step();
    checks++; if (valid !== 1'b1 || pc !== 32'h200 || instr !== mem_word(32'h200)) begin fails++; $display("FAIL instr_200 got %0b/%h/%h want 1/200/%h", valid, pc, instr, mem_word(32'h200)); end
    $display("flush_kill: pc=%h valid=%0b", pc, valid);
  endtask

  task automatic test_flush_and_stall();
    flush = 1'b1;
    hazard_stall = 1'b1;
    target_pc = 32'h200;
    step();
    flush = 1'b0;
    hazard_stall = 1'b0;
    checks++; if (valid !== 1'b0 || instr !== NOP_W) begin fails++; $display("FAIL fs_bubble got %0b/%h want 0/%h", valid, instr, NOP_W); end
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL fs_req got %0b/%h want 1/200", imem_req, imem_addr); end
    step();
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL fs_wait got %0b want 0", valid); end
    step();
    checks++; if (valid !== 1'b1 || pc !== 32'h200) begin fails++; $display("FAIL fs_next got %0b/%h want 1/200", valid, pc); end
`ifdef IFU_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd2) begin fails++; $display("FAIL stallcnt_flush got %0d want 2", stall_cycles); end
`endif
    $display("flush_and_stall: pc=%h valid=%0b", pc, valid);
  endtask

  task automatic test_pc_wrap();
    flush = 1'b1;
    target_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_req0 got %0b/%h want 1/fffffffc", imem_req, imem_addr); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_req1 got %0b/%h want 1/0", imem_req, imem_addr); end
    step();
    checks++; if (valid !== 1'b1 || pc !== 32'hFFFF_FFFC || instr !== mem_word(32'hFFFF_FFFC)) begin fails++; $display("FAIL wrap_instr0 got %0b/%h/%h", valid, pc, instr); end
    step();
    checks++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== mem_word(32'h0)) begin fails++; $display("FAIL wrap_instr1 got %0b/%h/%h", valid, pc, instr); end
    $display("pc_wrap: pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_reset_mid_wait();
    bit seen = 1'b0;
    lat = 3;
    step();
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL mid_rst got req=%0b valid=%0b want 0/0", imem_req, valid); end
    checks++; if (pc !== RST_PC || instr !== NOP_W) begin fails++; $display("FAIL mid_rst_ifid got %h/%h want %h/%h", pc, instr, RST_PC, NOP_W); end
    step();
    step();
    reset = 1'b0;
    inj_rvalid = 1'b1;
    inj_data = 32'hBAD0_BAD0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin fails++; $display("FAIL post_rst_req got %0b/%h want 1/%h", imem_req, imem_addr, RST_PC); end
    step();
    inj_rvalid = 1'b0;
    checks++; if (valid !== 1'b0 || instr !== NOP_W) begin fails++; $display("FAIL stale_ignored got %0b/%h want 0/%h", valid, instr, NOP_W); end
`ifdef IFU_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL stallcnt_rst got %0d want 0", stall_cycles); end
`endif
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin fails++; $display("FAIL post_rst_timeout got valid=0 want valid=1 within 10 cycles"); end
    checks++; if (pc !== RST_PC || instr !== mem_word(RST_PC)) begin fails++; $display("FAIL post_rst_instr got %h/%h want %h/%h", pc, instr, RST_PC, mem_word(RST_PC)); end
    $display("reset_mid_wait: pc=%h instr=%h", pc, instr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_stream();
    test_stall_skid();
    test_flush_kill();
    test_flush_and_stall();
    test_pc_wrap();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
